instruction_loader: RTL and testbench

- Host-side initiator for the pipeline's instruction-memory write port and halt input. Drives i_write_instruction_flag, i_instruction_to_write, i_address_to_write_inst and i_halt of pipeline.
- Consumes a byte stream from the UART receiver, assembles 32-bit words MSB-first and writes them to consecutive word addresses.
- Also accepts run/halt commands from the same stream.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/instruction_loader_word_assembler.sv | 46 ++++
 rtl/instruction_loader.sv | 132 +++++++++++++
 tb/tb_instruction_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, default
// command bytes and the word-index to byte-address helper.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GET_COUNT = 2'd1,
    ST_GET_BYTES = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int unsigned MAX_WORDS_DEF = 64;
  localparam logic [7:0]  CMD_LOAD_DEF  = 8'h4C;  // 'L'
  localparam logic [7:0]  CMD_RUN_DEF   = 8'h53;  // 'S'
  localparam logic [7:0]  CMD_HALT_DEF  = 8'h48;  // 'H'

  // Word index k -> byte address 4*k on the 32-bit memory bus.
  function automatic logic [31:0] word_addr(input logic [7:0] k);
    return {22'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Byte-to-word assembler: collects four bytes MSB-first and presents the
// completed word with a one-cycle valid pulse. The output word only
// changes on a stored completion, so it holds between writes.
module word_assembler (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  input  logic        i_store,
  output logic        o_last,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_word_valid;

  // Current byte completes a word.
  assign o_last       = i_byte_vld && (r_cnt == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  // Shift bytes in, count 0..3, latch the finished word when allowed.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= o_last && i_store;
      if (i_clr) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (i_byte_vld) begin
        r_shift <= {r_shift[15:0], i_byte};
        r_cnt   <= r_cnt + 2'd1;
        if (o_last && i_store) r_word <= {r_shift, i_byte};
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Host-side loader: decodes run/halt/load commands from the UART byte
// stream, writes assembled instruction words into the pipeline's
// instruction memory and controls the pipeline halt.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [7:0]  CMD_LOAD  = CMD_LOAD_DEF,
  parameter logic [7:0]  CMD_RUN   = CMD_RUN_DEF,
  parameter logic [7:0]  CMD_HALT  = CMD_HALT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_write_instruction_flag,
  output logic [31:0] o_instruction_to_write,
  output logic [31:0] o_address_to_write_inst,
  output logic        o_halt,
  output logic        o_busy,
  output logic        o_load_done,
  output logic        o_overflow
);

  state_t      r_state, w_next;
  logic [7:0]  r_k;         // words completed in this load
  logic [7:0]  r_n;         // words requested
  logic [31:0] r_addr;
  logic        r_halt;
  logic        r_overflow;

  logic        w_byte_vld;
  logic        w_last;
  logic        w_store;
  logic        w_word_valid;
  logic [31:0] w_word;
  logic        w_busy;
  logic        w_load_done;

  // Bytes after the N-th word (while waiting to enter DONE) are not taken.
  assign w_byte_vld = i_rx_valid && (r_state == ST_GET_BYTES) && (r_k != r_n);
  assign w_store    = 32'(r_k) < MAX_WORDS;

  word_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clr        (r_state != ST_GET_BYTES),
    .i_byte_vld   (w_byte_vld),
    .i_byte       (i_rx_data),
    .i_store      (w_store),
    .o_last       (w_last),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_load_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) w_next = ST_GET_COUNT;
      end
      ST_GET_COUNT: begin
        if (i_rx_valid) w_next = (i_rx_data == 8'd0) ? ST_IDLE : ST_GET_BYTES;
      end
      ST_GET_BYTES: begin
        // Entered DONE one cycle after the last word so the done pulse
        // follows the final write strobe.
        if (r_k == r_n) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_load_done = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: command effects, word count, address and overflow tracking.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_k        <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_halt     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD)      r_overflow <= 1'b0;
            else if (i_rx_data == CMD_RUN)  r_halt     <= 1'b0;
            else if (i_rx_data == CMD_HALT) r_halt     <= 1'b1;
          end
        end
        ST_GET_COUNT: begin
          if (i_rx_valid) begin
            r_n <= i_rx_data;
            r_k <= '0;
            if (i_rx_data != 8'd0) r_halt <= 1'b1;
          end
        end
        ST_GET_BYTES: begin
          if (w_last) begin
            r_k <= r_k + 8'd1;
            if (w_store) r_addr     <= word_addr(r_k);
            else         r_overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_write_instruction_flag = w_word_valid;
  assign o_instruction_to_write   = w_word;
  assign o_address_to_write_inst  = r_addr;
  assign o_halt                   = r_halt;
  assign o_busy                   = w_busy;
  assign o_load_done              = w_load_done;
  assign o_overflow               = r_overflow;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus pushes expected
// writes/done pulses, a negedge monitor pops and compares them.
module tb_instruction_loader;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        o_write_instruction_flag;
  logic [31:0] o_instruction_to_write;
  logic [31:0] o_address_to_write_inst;
  logic        o_halt, o_busy, o_load_done, o_overflow;

  instruction_loader #(.MAX_WORDS(2)) dut (
    .i_clk                    (i_clk),
    .i_reset                  (i_reset),
    .i_rx_data                (i_rx_data),
    .i_rx_valid               (i_rx_valid),
    .o_write_instruction_flag (o_write_instruction_flag),
    .o_instruction_to_write   (o_instruction_to_write),
    .o_address_to_write_inst  (o_address_to_write_inst),
    .o_halt                   (o_halt),
    .o_busy                   (o_busy),
    .o_load_done              (o_load_done),
    .o_overflow               (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          cyc;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe / done pulse must match the head of its queue.
  always @(negedge i_clk) begin : mon
    wr_t e;
    int  dc;
    if (i_reset) begin
      if (o_write_instruction_flag) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_data", o_instruction_to_write, e.data);
          chk("wr_addr", o_address_to_write_inst, e.addr);
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_halt", {31'd0, o_halt}, 32'd1);
        end
      end
      if (o_load_done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          dc = exp_done.pop_front();
          chk("done_cycle", cyc, dc);
          chk("done_halt", {31'd0, o_halt}, 32'd1);
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Four bytes MSB-first; expected strobe in the cycle after the 4th byte.
  task automatic put_word(input logic [31:0] w, input logic [7:0] k, input bit store);
    wr_t e;
    put(w[31:24]);
    put(w[23:16]);
    put(w[15:8]);
    put(w[7:0]);
    if (store) begin
      e.data = w;
      e.addr = {22'd0, k, 2'b00};
      e.cyc  = cyc;
      exp_wr.push_back(e);
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_halt", {31'd0, o_halt}, 32'd1);
    chk("rst_flag", {31'd0, o_write_instruction_flag}, 32'd0);
    chk("rst_addr", o_address_to_write_inst, 32'd0);
    chk("rst_data", o_instruction_to_write, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_load_done}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    i_reset = 1'b1;
    idle(1);

    // Run command releases halt on the next cycle
    put(8'h53);
    chk("run_halt", {31'd0, o_halt}, 32'd0);

    // Two-word load with a gap between words
    put(8'h4C);
    chk("load_busy", {31'd0, o_busy}, 32'd1);
    put(8'h02);
    chk("load_halt", {31'd0, o_halt}, 32'd1);
    put_word(32'h20010005, 8'd0, 1'b1);
    idle(2);
    put_word(32'hAC020000, 8'd1, 1'b1);
    exp_done.push_back(cyc + 1);
    idle(3);
    chk("load2_busy", {31'd0, o_busy}, 32'd0);
    chk("load2_halt", {31'd0, o_halt}, 32'd1);
    chk("load2_hold_data", o_instruction_to_write, 32'hAC020000);

    // Zero-length load: no writes, no done, back to IDLE
    put(8'h4C);
    put(8'h00);
    chk("n0_busy", {31'd0, o_busy}, 32'd0);
    idle(2);
    put(8'h53);
    chk("n0_run_halt", {31'd0, o_halt}, 32'd0);

    // Overflow: third word suppressed, bytes consumed, done still pulses
    put(8'h4C);
    put(8'h03);
    put_word(32'hA1A2A3A4, 8'd0, 1'b1);
    put_word(32'hB1B2B3B4, 8'd1, 1'b1);
    put_word(32'hC1C2C3C4, 8'd2, 1'b0);
    exp_done.push_back(cyc + 1);
    chk("ovf_set", {31'd0, o_overflow}, 32'd1);
    idle(3);
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
    chk("ovf_hold_addr", o_address_to_write_inst, 32'h4);
    chk("ovf_hold_data", o_instruction_to_write, 32'hB1B2B3B4);
    put(8'h4C);
    chk("ovf_clear", {31'd0, o_overflow}, 32'd0);
    put(8'h00);

    // Command codes as data, back-to-back bytes
    put(8'h4C);
    put(8'h01);
    put_word(32'h4C53484C, 8'd0, 1'b1);
    exp_done.push_back(cyc + 1);
    idle(3);
    chk("cmddata_halt", {31'd0, o_halt}, 32'd1);
    chk("cmddata_busy", {31'd0, o_busy}, 32'd0);

    // Reset in the middle of a word
    put(8'h4C);
    put(8'h01);
    put(8'hAA);
    put(8'hBB);
    #2 i_reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_halt", {31'd0, o_halt}, 32'd1);
    chk("midrst_flag", {31'd0, o_write_instruction_flag}, 32'd0);
    chk("midrst_addr", o_address_to_write_inst, 32'd0);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    idle(2);
    put(8'h4C);
    put(8'h01);
    put_word(32'h11223344, 8'd0, 1'b1);
    exp_done.push_back(cyc + 1);
    idle(4);

    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("done_queue_empty", exp_done.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
